regfile_dualwb_sb: RTL and testbench
====================================

Name: regfile_dualwb_sb

Overview:
- Parametrised successor to the 16x16 dual-write register file used in the 5-stage pipeline.
- Adds configurable width and depth, an optional hardwired-zero register, write-to-read bypass, and write-conflict detection.
- Adds a per-register pending (scoreboard) bit so the decode stage can detect RAW hazards on in-flight destinations.
- Sits between the ID stage (reads, scoreboard set) and the WB stage (two write ports; port 2 carries the multiply/divide high result).

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- SPECIAL_REG, 15, index of the register mirrored continuously on spec_out
- ZERO_REG_EN, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS_EN, 1, 1 = same-cycle write data is forwarded to read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_data2  out  DATA_W  read port 2 data, combinational
- wr_en1  in  1  write port 1 enable
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- wr_en2  in  1  write port 2 enable
- wr_addr2  in  ADDR_W  write port 2 address
- wr_data2  in  DATA_W  write port 2 data
- sb_set_en  in  1  mark destination pending (instruction issued)
- sb_set_addr  in  ADDR_W  destination to mark pending
- busy1  out  1  pending status of rd_addr1, combinational
- busy2  out  1  pending status of rd_addr2, combinational
- spec_out  out  DATA_W  registered contents of SPECIAL_REG
- wr_conflict  out  1  registered one-cycle pulse: both write ports hit the same address

Behaviour:
- Reset: on a rising edge with rst=1, all registers, all pending bits and wr_conflict clear to 0. Reset overrides any same-cycle write or set. Reads during reset follow the normal combinational rules.
- Writes: commit on the rising edge, so data is visible in storage from the next cycle.
- Write conflict: if wr_en1 and wr_en2 and wr_addr1==wr_addr2, port 2 wins. wr_conflict is 1 in the following cycle only.
- Zero register: with ZERO_REG_EN=1, writes to address 0 are dropped. Reads of address 0 return 0, including bypass. Pending bit 0 is never set; busy for address 0 is always 0.
- Read, BYPASS_EN=1: if a write port is enabled to rd_addrN this cycle, rd_dataN returns that write's data. Port 2 takes precedence over port 1. Otherwise rd_dataN returns stored data.
- Read, BYPASS_EN=0: rd_dataN always returns stored data (pre-edge value).
- spec_out: equals stored SPECIAL_REG. It updates the cycle after a write to it and is never bypassed.
- Scoreboard set/clear:
  - Pending bit for A sets on an edge with sb_set_en and sb_set_addr==A.
  - It clears on an edge where either write port writes A.
  - Set and clear of the same A in one cycle: set wins, because a newer producer was issued.
- busy output:
  - busyN = pending[rd_addrN].
  - With BYPASS_EN=1, busyN is forced to 0 when a write to rd_addrN is present this cycle, since the data is forwarded.
  - busyN does not reflect a same-cycle sb_set (no set-to-busy bypass).
- Arithmetic: none. Data is stored verbatim with no truncation or extension.
- Out-of-range addresses cannot occur (depth = 2**ADDR_W).

Test Plan:
- Reset then read: after rst=1 for one edge, read r0/r1 -> rd_data1=rd_data2=0, busy1=busy2=0, spec_out=0, wr_conflict=0.
- Dual write: wr1 r3=0x1234, wr2 r15=0xBEEF. Next cycle read r3/r15 -> 0x1234/0xBEEF; spec_out=0xBEEF from that cycle on.
- Bypass: r5 holds 0x0001; same cycle wr1 r5=0x00AA and rd_addr1=5 -> rd_data1=0x00AA (0x0001 with BYPASS_EN=0). Same cycle wr1 r5=0x1111 and wr2 r5=0x2222 -> rd_data=0x2222.
- Conflict: wr1 r7=0x1111 and wr2 r7=0x2222 on one edge -> r7=0x2222 and wr_conflict=1 for exactly one cycle, then 0.
- Scoreboard:
  - sb_set r9; next cycle rd_addr1=9 -> busy1=1.
  - Cycle with wr2 r9=0x0042 -> busy1=0, rd_data1=0x0042; after the edge, pending cleared.
  - Set and write r9 on the same edge -> busy1=1 afterwards.
- Zero register and mid-run reset:
  - ZERO_REG_EN=1: write r0=0xFFFF -> r0 reads 0, sb_set r0 -> busy=0.
  - Assert rst with pending r9 and r15=0xBEEF -> next cycle busy=0, spec_out=0.

Source files
------------

// File: rtl/regfile_dualwb_sb.sv
// Parametrised dual-write register file with write-to-read bypass, write-conflict
// detection and a per-register pending (scoreboard) bit for RAW hazard detection.
module regfile_dualwb_sb #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SPECIAL_REG = 15,
    parameter int unsigned ZERO_REG_EN = 0,
    parameter int unsigned BYPASS_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [DATA_W-1:0] spec_out,
    output logic              wr_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              conflict_q, conflict_d;
    logic              wr1_ok, wr2_ok, set_ok;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG_EN != 0) && (a == '0);
    endfunction

    // Writes and sets aimed at a hardwired zero register are dropped up front.
    always_comb begin
        wr1_ok = wr_en1 && !is_zero_reg(wr_addr1);
        wr2_ok = wr_en2 && !is_zero_reg(wr_addr2);
        set_ok = sb_set_en && !is_zero_reg(sb_set_addr);
    end

    // Next state: port 2 overrides port 1, and a new issue overrides a writeback clear.
    always_comb begin
        mem_d      = mem_q;
        pend_d     = pend_q;
        conflict_d = wr_en1 && wr_en2 && (wr_addr1 == wr_addr2);
        if (wr1_ok) begin
            mem_d[wr_addr1]  = wr_data1;
            pend_d[wr_addr1] = 1'b0;
        end
        if (wr2_ok) begin
            mem_d[wr_addr2]  = wr_data2;
            pend_d[wr_addr2] = 1'b0;
        end
        if (set_ok) begin
            pend_d[sb_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (is_zero_reg(a)) begin
            return '0;
        end
        if ((BYPASS_EN != 0) && wr2_ok && (wr_addr2 == a)) begin
            return wr_data2;
        end
        if ((BYPASS_EN != 0) && wr1_ok && (wr_addr1 == a)) begin
            return wr_data1;
        end
        return mem_q[a];
    endfunction

    // A forwarded write hides the pending bit because the data is already available.
    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        if (is_zero_reg(a)) begin
            return 1'b0;
        end
        if ((BYPASS_EN != 0) && ((wr1_ok && (wr_addr1 == a)) || (wr2_ok && (wr_addr2 == a)))) begin
            return 1'b0;
        end
        return pend_q[a];
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
        busy1    = busy_port(rd_addr1);
        busy2    = busy_port(rd_addr2);
    end

    assign spec_out    = mem_q[ADDR_W'(SPECIAL_REG)];
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_dualwb_sb.sv
// Bench for regfile_dualwb_sb: a default instance checked against a vector table and a
// zero-register/no-bypass instance checked against a reference model.
module tb_regfile_dualwb_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra1, ra2, wa1, wa2, sba;
    logic        we1, we2, sbe;
    logic [15:0] wd1, wd2;

    logic [15:0] a_rd1, a_rd2, a_spec, b_rd1, b_rd2, b_spec;
    logic        a_b1, a_b2, a_conf, b_b1, b_b2, b_conf;

    always #5 clk = ~clk;

    regfile_dualwb_sb dut (
        .clk(clk), .rst(rst), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(a_rd1), .rd_data2(a_rd2),
        .wr_en1(we1), .wr_addr1(wa1), .wr_data1(wd1),
        .wr_en2(we2), .wr_addr2(wa2), .wr_data2(wd2),
        .sb_set_en(sbe), .sb_set_addr(sba),
        .busy1(a_b1), .busy2(a_b2), .spec_out(a_spec), .wr_conflict(a_conf)
    );

    regfile_dualwb_sb #(.ZERO_REG_EN(1), .BYPASS_EN(0)) dut_z (
        .clk(clk), .rst(rst), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(b_rd1), .rd_data2(b_rd2),
        .wr_en1(we1), .wr_addr1(wa1), .wr_data1(wd1),
        .wr_en2(we2), .wr_addr2(wa2), .wr_data2(wd2),
        .sb_set_en(sbe), .sb_set_addr(sba),
        .busy1(b_b1), .busy2(b_b2), .spec_out(b_spec), .wr_conflict(b_conf)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  ra1, ra2;
        logic        we1;
        logic [3:0]  wa1;
        logic [15:0] wd1;
        logic        we2;
        logic [3:0]  wa2;
        logic [15:0] wd2;
        logic        sbe;
        logic [3:0]  sba;
        logic        chk;
        logic [15:0] e_rd1, e_rd2;
        logic        e_b1, e_b2;
        logic [15:0] e_spec;
        logic        e_conf;
    } vec_t;

    typedef struct {
        logic [15:0] rd1, rd2, spec;
        logic        b1, b2, conf;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    logic [15:0] mem_m [16];
    logic [15:0] pend_m;
    logic        conf_m;

    function automatic vec_t mk(
        input logic r, input logic [3:0] a1, input logic [3:0] a2,
        input logic e1, input logic [3:0] w1, input logic [15:0] d1,
        input logic e2, input logic [3:0] w2, input logic [15:0] d2,
        input logic se, input logic [3:0] sa, input logic c,
        input logic [15:0] x1, input logic [15:0] x2, input logic y1, input logic y2,
        input logic [15:0] xs, input logic xc);
        vec_t v;
        v.rst = r; v.ra1 = a1; v.ra2 = a2;
        v.we1 = e1; v.wa1 = w1; v.wd1 = d1;
        v.we2 = e2; v.wa2 = w2; v.wd2 = d2;
        v.sbe = se; v.sba = sa; v.chk = c;
        v.e_rd1 = x1; v.e_rd2 = x2; v.e_b1 = y1; v.e_b2 = y2;
        v.e_spec = xs; v.e_conf = xc;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Expected output of the zero-register/no-bypass instance from the model state.
    function automatic exp_t model_exp();
        exp_t e;
        e.rd1  = (ra1 == 4'd0) ? 16'h0 : mem_m[ra1];
        e.rd2  = (ra2 == 4'd0) ? 16'h0 : mem_m[ra2];
        e.b1   = (ra1 == 4'd0) ? 1'b0 : pend_m[ra1];
        e.b2   = (ra2 == 4'd0) ? 1'b0 : pend_m[ra2];
        e.spec = mem_m[15];
        e.conf = conf_m;
        return e;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
            pend_m = 16'h0;
            conf_m = 1'b0;
        end else begin
            conf_m = we1 && we2 && (wa1 == wa2);
            if (we1 && wa1 != 4'd0) begin mem_m[wa1] = wd1; pend_m[wa1] = 1'b0; end
            if (we2 && wa2 != 4'd0) begin mem_m[wa2] = wd2; pend_m[wa2] = 1'b0; end
            if (sbe && sba != 4'd0) pend_m[sba] = 1'b1;
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [15:0] rd1,
                           input logic [15:0] rd2, input logic b1, input logic b2,
                           input logic [15:0] spec, input logic conf);
        check({tag, ".rd_data1"}, rd1, e.rd1);
        check({tag, ".rd_data2"}, rd2, e.rd2);
        check({tag, ".busy1"}, 16'(b1), 16'(e.b1));
        check({tag, ".busy2"}, 16'(b2), 16'(e.b2));
        check({tag, ".spec_out"}, spec, e.spec);
        check({tag, ".wr_conflict"}, 16'(conf), 16'(e.conf));
    endtask

    task automatic step(input vec_t v, input logic chk_a, input int idx);
        exp_t ea, eb;
        @(negedge clk);
        rst = v.rst; ra1 = v.ra1; ra2 = v.ra2;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        we2 = v.we2; wa2 = v.wa2; wd2 = v.wd2;
        sbe = v.sbe; sba = v.sba;
        #1;
        if (v.chk) begin
            ea.rd1 = v.e_rd1; ea.rd2 = v.e_rd2; ea.b1 = v.e_b1; ea.b2 = v.e_b2;
            ea.spec = v.e_spec; ea.conf = v.e_conf;
            if (chk_a) sb_q.push_back(ea);
            sb_q.push_back(model_exp());
            if (chk_a) begin
                ea = sb_q.pop_front();
                compare($sformatf("v%0d.def", idx), ea, a_rd1, a_rd2, a_b1, a_b2, a_spec, a_conf);
            end
            eb = sb_q.pop_front();
            compare($sformatf("v%0d.zro", idx), eb, b_rd1, b_rd2, b_b1, b_b2, b_spec, b_conf);
        end
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        vec_t r;
        rst = 1'b1; ra1 = '0; ra2 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
        we2 = 1'b0; wa2 = '0; wd2 = '0; sbe = 1'b0; sba = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
        pend_m = 16'h0; conf_m = 1'b0;

        //       rst ra1 ra2 we1 wa1 wd1      we2 wa2 wd2      sbe sba chk rd1      rd2      b1 b2 spec     conf
        tbl.push_back(mk(1, 0,  1,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 0,  1,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h0,    16'h0,    0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 3,  15, 1, 3, 16'h1234, 1, 15, 16'hBEEF, 0, 0, 1, 16'h1234, 16'hBEEF, 0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 3,  15, 0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h1234, 16'hBEEF, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 5,  5,  1, 5, 16'h0001, 0, 0,  16'h0,    0, 0, 1, 16'h0001, 16'h0001, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 5,  3,  1, 5, 16'h00AA, 0, 0,  16'h0,    0, 0, 1, 16'h00AA, 16'h1234, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 5,  5,  1, 5, 16'h1111, 1, 5,  16'h2222, 0, 0, 1, 16'h2222, 16'h2222, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 5,  5,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h2222, 16'h2222, 0, 0, 16'hBEEF, 1));
        tbl.push_back(mk(0, 7,  7,  1, 7, 16'h1111, 1, 7,  16'h2222, 0, 0, 1, 16'h2222, 16'h2222, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 7,  5,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h2222, 16'h2222, 0, 0, 16'hBEEF, 1));
        tbl.push_back(mk(0, 7,  7,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h2222, 16'h2222, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  9,  0, 0, 16'h0,    0, 0,  16'h0,    1, 9, 1, 16'h0,    16'h0,    0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  3,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h0,    16'h1234, 1, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  9,  0, 0, 16'h0,    1, 9,  16'h0042, 0, 0, 1, 16'h0042, 16'h0042, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  9,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h0042, 16'h0042, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  9,  1, 9, 16'h0055, 0, 0,  16'h0,    1, 9, 1, 16'h0055, 16'h0055, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  9,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h0055, 16'h0055, 1, 1, 16'hBEEF, 0));
        tbl.push_back(mk(1, 9,  15, 1, 3, 16'h7777, 0, 0,  16'h0,    1, 3, 1, 16'h0055, 16'hBEEF, 1, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 9,  3,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h0,    16'h0,    0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 15, 3,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h0,    16'h0,    0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 0,  0,  1, 0, 16'hFFFF, 0, 0,  16'h0,    1, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'hFFFF, 16'hFFFF, 1, 1, 16'h0,    0));
        tbl.push_back(mk(0, 0,  0,  1, 0, 16'h5678, 1, 0,  16'h1234, 0, 0, 1, 16'h1234, 16'h1234, 0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 16'h0,    0, 0,  16'h0,    0, 0, 1, 16'h1234, 16'h1234, 0, 0, 16'h0,    1));

        foreach (tbl[i]) step(tbl[i], 1'b1, i);

        // Random traffic on a narrow address range to force collisions, checked on the model instance.
        for (int i = 0; i < 80; i++) begin
            r = mk(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'b1,
                   16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
            if (i % 10 == 5) r.ra2 = 4'd15;
            if (i % 10 == 3) begin r.we1 = 1'b1; r.wa1 = 4'd15; end
            step(r, 1'b0, 100 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
